// File: rtl/wiegand_pkg.sv
`default_nettype none
// ============================================================================
// Package  : wiegand_pkg
// Purpose  : Shared Wiegand-26 frame constants and parity check helper
// Revision : 1.0
// ============================================================================
package wiegand_pkg;

  localparam int WG_DATA_W = 26;
  localparam int CH_ID_W   = 2;
  localparam int ENTRY_W   = CH_ID_W + 1 + WG_DATA_W;

  // Leading bit is even parity over the upper half, trailing bit odd parity over the lower half
  localparam int EVEN_PAR_BIT = 25;
  localparam int EVEN_HI      = 24;
  localparam int EVEN_LO      = 13;
  localparam int ODD_PAR_BIT  = 0;
  localparam int ODD_HI       = 12;
  localparam int ODD_LO       = 1;

  function automatic logic wg_perr(input logic [WG_DATA_W-1:0] f);
    logic even_bad;
    logic odd_bad;
    even_bad = f[EVEN_PAR_BIT] ^ (^f[EVEN_HI:EVEN_LO]);
    odd_bad  = ~(f[ODD_PAR_BIT] ^ (^f[ODD_HI:ODD_LO]));
    return even_bad | odd_bad;
  endfunction

endpackage
`default_nettype wire

// File: rtl/wiegand_fifo.sv
`default_nettype none
// ============================================================================
// Module   : wiegand_fifo
// Purpose  : Single-clock FIFO with full/empty and same-cycle push/pop
// Revision : 1.0
// ============================================================================
module wiegand_fifo #(
  parameter int WIDTH = 29,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = pop_i & ~empty_o;
  // A pop in the same cycle frees the slot a full FIFO needs for the push
  assign do_push = push_i & (~full_o | do_pop);
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule
`default_nettype wire

// File: rtl/wiegand_rx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wiegand_rx_arbiter
// Purpose  : Multi-channel Wiegand frame capture merged round-robin into a FIFO
// Revision : 1.0
// ============================================================================
module wiegand_rx_arbiter
  import wiegand_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int DEPTH  = 4,
  parameter int DATA_W = WG_DATA_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  input  logic [NUM_CH-1:0]        ch_int,
  input  logic [NUM_CH-1:0]        ch_en,
  input  logic                     rd_en,
  input  logic                     ovf_clr,
  output logic [CH_ID_W+DATA_W:0]  rd_data,
  output logic                     rd_valid,
  output logic                     irq,
  output logic [NUM_CH-1:0]        ovf,
  output logic [NUM_CH*8-1:0]      frame_cnt
);

  localparam int IDX_W = $clog2(NUM_CH);
  localparam int ENT_W = CH_ID_W + 1 + DATA_W;
  localparam logic [IDX_W-1:0] LAST_CH = IDX_W'(NUM_CH - 1);

  logic [NUM_CH-1:0] sync1_q, sync2_q, prev_q, rise;
  logic [NUM_CH-1:0] pend_v_q, pend_v_d, pend_perr_q;
  logic [NUM_CH-1:0] ovf_q, ovf_d, ovf_set;
  logic [DATA_W-1:0] pend_frame_q [NUM_CH];
  logic [DATA_W-1:0] frame_in [NUM_CH];
  logic [7:0]        cnt_q [NUM_CH];
  logic [IDX_W-1:0]  ptr_q, gnt_idx;
  logic              gnt_vld, push, drop, fifo_full, fifo_empty;
  logic [ENT_W-1:0]  push_data;

  generate
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      assign frame_in[i]         = ch_data[i*DATA_W +: DATA_W];
      assign frame_cnt[i*8 +: 8] = cnt_q[i];
    end
  endgenerate

  // Frame-done is the release of the active-low flag after synchronization
  assign rise = sync2_q & ~prev_q & ch_en;

  always_comb begin : arb
    logic [IDX_W-1:0] cand;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = ptr_q;
    for (int k = 0; k < NUM_CH; k++) begin
      cand = (cand == LAST_CH) ? '0 : cand + IDX_W'(1);
      if (!gnt_vld && pend_v_q[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  assign push      = gnt_vld & (~fifo_full | rd_en);
  assign drop      = gnt_vld & fifo_full & ~rd_en;
  assign push_data = {CH_ID_W'(gnt_idx), pend_perr_q[gnt_idx], pend_frame_q[gnt_idx]};

  always_comb begin
    pend_v_d = pend_v_q;
    ovf_set  = '0;
    if (gnt_vld) begin
      pend_v_d[gnt_idx] = 1'b0;
      if (drop) ovf_set[gnt_idx] = 1'b1;
    end
    // A completion landing on a still-occupied pending slot overwrites it
    for (int i = 0; i < NUM_CH; i++) begin
      if (rise[i]) begin
        if (pend_v_d[i]) ovf_set[i] = 1'b1;
        pend_v_d[i] = 1'b1;
      end
    end
    ovf_d = (ovf_q & ~{NUM_CH{ovf_clr}}) | ovf_set;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q     <= '1;
      sync2_q     <= '1;
      prev_q      <= '1;
      pend_v_q    <= '0;
      pend_perr_q <= '0;
      ovf_q       <= '0;
      ptr_q       <= LAST_CH;
      for (int i = 0; i < NUM_CH; i++) begin
        pend_frame_q[i] <= '0;
        cnt_q[i]        <= '0;
      end
    end else begin
      sync1_q  <= ch_int;
      sync2_q  <= sync1_q;
      prev_q   <= sync2_q;
      pend_v_q <= pend_v_d;
      ovf_q    <= ovf_d;
      if (gnt_vld) ptr_q <= gnt_idx;
      for (int i = 0; i < NUM_CH; i++) begin
        if (rise[i]) begin
          pend_frame_q[i] <= frame_in[i];
          pend_perr_q[i]  <= wg_perr(frame_in[i][WG_DATA_W-1:0]);
        end
      end
      if (push) cnt_q[gnt_idx] <= cnt_q[gnt_idx] + 8'd1;
    end
  end

  wiegand_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (rd_en),
    .wdata_i (push_data),
    .rdata_o (rd_data),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  assign rd_valid = ~fifo_empty;
  assign irq      = rd_valid;
  assign ovf      = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_wiegand_rx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_wiegand_rx_arbiter
// Purpose  : Directed bench with a queue-based reference model of the receiver
// Revision : 1.0
// ============================================================================
module tb_wiegand_rx_arbiter;

  localparam int NCH = 2;
  localparam int DEP = 4;
  localparam int DW  = 26;

  logic              clk = 1'b0;
  logic              rst;
  logic [NCH*DW-1:0] ch_data;
  logic [NCH-1:0]    ch_int, ch_en;
  logic              rd_en, ovf_clr;
  logic [DW+2:0]     rd_data;
  logic              rd_valid, irq;
  logic [NCH-1:0]    ovf;
  logic [NCH*8-1:0]  frame_cnt;

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  wiegand_rx_arbiter #(.NUM_CH(NCH), .DEPTH(DEP), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .ch_data(ch_data), .ch_int(ch_int), .ch_en(ch_en),
    .rd_en(rd_en), .ovf_clr(ovf_clr), .rd_data(rd_data), .rd_valid(rd_valid),
    .irq(irq), .ovf(ovf), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit exp_perr(input logic [DW-1:0] f);
    return (($countones(f[25:13]) % 2) != 0) || (($countones(f[12:0]) % 2) != 1);
  endfunction

  function automatic logic [DW-1:0] mk_valid(input logic [23:0] d);
    return {^d[23:12], d, ~^d[11:0]};
  endfunction

  // ---------------- reference model: pending slots, RR pointer, queue FIFO
  logic [NCH-1:0] m_s1, m_s2, m_prev, m_ovf, m_set;
  bit             m_pv [NCH];
  logic [DW-1:0]  m_pf [NCH];
  bit             m_pp [NCH];
  logic [7:0]     m_cnt [NCH];
  logic [DW+2:0]  m_q [$];
  int             m_last, m_g;
  bit             m_full;

  always @(posedge clk) begin
    if (rst) begin
      m_s1 = '1; m_s2 = '1; m_prev = '1; m_ovf = '0;
      m_q.delete();
      m_last = NCH - 1;
      for (int i = 0; i < NCH; i++) begin
        m_pv[i] = 0; m_pf[i] = '0; m_pp[i] = 0; m_cnt[i] = '0;
      end
    end else begin
      m_set  = '0;
      m_g    = -1;
      m_full = (m_q.size() == DEP);
      for (int k = 1; k <= NCH; k++) begin
        if (m_g < 0 && m_pv[(m_last + k) % NCH]) m_g = (m_last + k) % NCH;
      end
      if (rd_en && m_q.size() > 0) void'(m_q.pop_front());
      if (m_g >= 0) begin
        if (!m_full || rd_en) begin
          m_q.push_back({2'(m_g), m_pp[m_g], m_pf[m_g]});
          m_cnt[m_g] = m_cnt[m_g] + 8'd1;
        end else begin
          m_set[m_g] = 1'b1;
        end
        m_pv[m_g] = 0;
        m_last    = m_g;
      end
      for (int i = 0; i < NCH; i++) begin
        if (m_s2[i] && !m_prev[i] && ch_en[i]) begin
          if (m_pv[i]) m_set[i] = 1'b1;
          m_pv[i] = 1;
          m_pf[i] = ch_data[i*DW +: DW];
          m_pp[i] = exp_perr(ch_data[i*DW +: DW]);
        end
      end
      m_ovf  = (ovf_clr ? '0 : m_ovf) | m_set;
      m_prev = m_s2;
      m_s2   = m_s1;
      m_s1   = ch_int;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("rd_valid", rd_valid, m_q.size() != 0);
      chk("irq", irq, m_q.size() != 0);
      chk("rd_data", rd_data, (m_q.size() != 0) ? m_q[0] : '0);
      chk("ovf", ovf, m_ovf);
      chk("frame_cnt", frame_cnt, {m_cnt[1], m_cnt[0]});
    end
  end

  // ---------------- stimulus
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic lower(input logic [NCH-1:0] mask, input logic [DW-1:0] f0, input logic [DW-1:0] f1);
    if (mask[0]) ch_data[0 +: DW]  = f0;
    if (mask[1]) ch_data[DW +: DW] = f1;
    ch_int = ch_int & ~mask;
    tick(3);
  endtask

  task automatic send(input logic [NCH-1:0] mask, input logic [DW-1:0] f0, input logic [DW-1:0] f1);
    lower(mask, f0, f1);
    ch_int = ch_int | mask;
    tick(6);
  endtask

  task automatic pop1();
    rd_en = 1'b1;
    tick(1);
    rd_en = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
  endtask

  logic [DW-1:0] fa, fb;
  int n;

  initial begin
    rst = 1'b1; ch_data = '0; ch_int = '1; ch_en = '1; rd_en = 1'b0; ovf_clr = 1'b0;
    tick(3);
    rst = 1'b0;
    chk_on = 1'b1;
    tick(1);

    // model pins
    chk("pin_mk0", mk_valid(24'h000000), 26'h0000001);
    chk("pin_mk1", mk_valid(24'h800000), 26'h3000001);
    chk("pin_perr_ok", exp_perr(26'h3000001), 1'b0);
    chk("pin_perr_bad", exp_perr(26'h2000002), 1'b1);

    // reset state
    chk("rst_valid", rd_valid, 1'b0);
    chk("rst_data", rd_data, 29'h0);
    chk("rst_ovf", ovf, 2'b00);
    chk("rst_cnt", frame_cnt, 16'h0000);

    // parity-error frame and its latency
    lower(2'b01, 26'h2000002, '0);
    ch_int[0] = 1'b1;
    tick(3);
    chk("lat_before", rd_valid, 1'b0);
    tick(1);
    chk("lat_at", rd_valid, 1'b1);
    chk("perr_entry", rd_data, 29'h6000002);
    pop1();
    tick(1);
    chk("perr_popped", rd_valid, 1'b0);

    // simultaneous completion: channel 0 first
    do_reset();
    fa = mk_valid(24'h012345);
    fb = mk_valid(24'h0ABCDE);
    send(2'b11, fa, fb);
    chk("sim_hd0", rd_data, {3'b000, fa});
    pop1();
    chk("sim_hd1", rd_data, {2'b01, 1'b0, fb});
    chk("sim_cnt", frame_cnt, 16'h0101);
    pop1();
    chk("sim_empty", rd_valid, 1'b0);

    // round robin: after a channel-0 grant, channel 1 wins next
    send(2'b01, mk_valid(24'h000111), '0);
    send(2'b11, mk_valid(24'h000222), mk_valid(24'h000333));
    pop1();
    chk("rr_ch1", rd_data[28:27], 2'd1);
    pop1();
    chk("rr_ch0", rd_data[28:27], 2'd0);
    pop1();

    // overflow by FIFO full
    do_reset();
    for (int i = 0; i < 5; i++) send(2'b10, '0, mk_valid(24'h100 + 24'(i)));
    chk("ovf_set", ovf, 2'b10);
    chk("ovf_cnt", frame_cnt[15:8], 8'd4);
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    chk("ovf_clr", ovf, 2'b00);

    // full FIFO with pop on the grant cycle accepts the write
    lower(2'b10, '0, mk_valid(24'h000777));
    ch_int[1] = 1'b1;
    tick(3);
    rd_en = 1'b1;
    tick(1);
    rd_en = 1'b0;
    tick(3);
    chk("fullpop_ovf", ovf, 2'b00);
    chk("fullpop_cnt", frame_cnt[15:8], 8'd5);
    n = 0;
    while (rd_valid && n < 10) begin
      pop1();
      n++;
    end
    chk("fullpop_depth", n, 4);

    // disabled channel, then reset with queued data
    do_reset();
    ch_en = 2'b10;
    send(2'b01, mk_valid(24'h000055), '0);
    chk("dis_valid", rd_valid, 1'b0);
    chk("dis_cnt", frame_cnt[7:0], 8'd0);
    ch_en = 2'b11;
    send(2'b11, mk_valid(24'h000066), mk_valid(24'h000077));
    chk("q2_valid", rd_valid, 1'b1);
    rst = 1'b1;
    tick(1);
    chk("rst_mid", rd_valid, 1'b0);
    rst = 1'b0;
    tick(10);
    chk("rst_after", rd_valid, 1'b0);

    // counter wrap
    do_reset();
    rd_en = 1'b1;
    for (int i = 0; i < 255; i++) send(2'b01, mk_valid(24'(i)), '0);
    chk("cnt_255", frame_cnt[7:0], 8'd255);
    send(2'b01, mk_valid(24'h00ABCD), '0);
    chk("cnt_wrap", frame_cnt[7:0], 8'd0);
    rd_en = 1'b0;
    tick(2);

    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
